// File: rtl/add4_seq.sv
// Sequential WIDTH-bit adder that reuses one 4-bit ripple slice per nibble, LSB first.
// Optional signed-overflow output is enabled by defining ADD4_SEQ_OVF_EN.

module add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0, ci};
endmodule

module add4_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef ADD4_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("add4_seq: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             cy_q;
  logic [IDX_W-1:0] idx_q;
  logic             last;
  logic [3:0]       nib_a, nib_b, nib_s;
  logic             nib_co;

  assign last  = (idx_q == IDX_W'(N - 1));
  assign nib_a = a_q[4*idx_q +: 4];
  assign nib_b = b_q[4*idx_q +: 4];

  add4 u_add4 (
    .a  (nib_a),
    .b  (nib_b),
    .ci (cy_q),
    .s  (nib_s),
    .co (nib_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Handshake flags decode only the state register, so no input reaches them combinationally.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      cy_q  <= 1'b0;
      idx_q <= '0;
      s     <= '0;
      co    <= 1'b0;
`ifdef ADD4_SEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q   <= a;
          b_q   <= b;
          cy_q  <= ci;
          idx_q <= '0;
        end
        RUN: begin
          s[4*idx_q +: 4] <= nib_s;
          cy_q            <= nib_co;
          idx_q           <= idx_q + 1'b1;
          if (last) begin
            co  <= nib_co;
`ifdef ADD4_SEQ_OVF_EN
            // carry into the MSB is recovered as a^b^s of that bit
            ovf <= (nib_a[3] ^ nib_b[3] ^ nib_s[3]) ^ nib_co;
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_add4_seq.sv
// Scoreboard bench for add4_seq: stimulus pushes model results, a monitor pops on each output transfer.
module tb_add4_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, ci, co;
  logic [W-1:0] a, b, s;
  logic         in_valid4, in_ready4, out_valid4, out_ready4, ci4, co4;
  logic [3:0]   a4, b4, s4;
`ifdef ADD4_SEQ_OVF_EN
  logic         ovf, ovf4;
`endif

  always #5 clk = ~clk;

  add4_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co)
`ifdef ADD4_SEQ_OVF_EN
    , .ovf(ovf)
`endif
  );

  add4_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .ci(ci4), .out_valid(out_valid4), .out_ready(out_ready4),
    .s(s4), .co(co4)
`ifdef ADD4_SEQ_OVF_EN
    , .ovf(ovf4)
`endif
  );

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: exact unsigned and signed integer sums.
  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
    exp_t   m;
    longint usum, sa, sb_v, ssum, lim;
    usum = longint'(xa) + longint'(xb) + longint'(xc);
    m.s  = usum[W-1:0];
    m.co = usum[W];
    lim  = longint'(1) << (W - 1);
    sa   = xa[W-1] ? longint'(xa) - (lim << 1) : longint'(xa);
    sb_v = xb[W-1] ? longint'(xb) - (lim << 1) : longint'(xb);
    ssum = sa + sb_v + longint'(xc);
    m.ovf = (ssum >= lim) || (ssum < -lim);
    return m;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("hs_exclusive", {63'b0, in_ready && out_valid}, 64'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_output: got s=%0h with empty scoreboard", s);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sum", s, e.s);
          check("carry", co, e.co);
`ifdef ADD4_SEQ_OVF_EN
          check("ovf", ovf, e.ovf);
`endif
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL issue_timeout: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1; a = xa; b = xb; ci = xc;
    @(posedge clk);
    sb.push_back(model(xa, xb, xc));
    #1;
    in_valid = 1'b0;
    a  = W'($urandom);
    b  = W'($urandom);
    ci = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input bit rnd);
    for (int t = 0; t < 200; t++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd) begin
        in_valid = 1'($urandom_range(0, 1));
        a        = W'($urandom);
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n_chk++;
    $display("FAIL drain_timeout: out_valid=%0b required 1", out_valid);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    in_valid = 0; a = '0; b = '0; ci = 0; out_ready = 0;
    in_valid4 = 0; a4 = '0; b4 = '0; ci4 = 0; out_ready4 = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_s", s, 0);
    check("rst_co", co, 0);
`ifdef ADD4_SEQ_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;

    // WIDTH=4 instance: a single RUN cycle
    in_valid4 = 1; a4 = 4'hF; b4 = 4'h1; ci4 = 0;
    @(posedge clk); #1;
    in_valid4 = 0;
    check("w4_run_valid", out_valid4, 0);
    @(posedge clk); #1;
    check("w4_valid", out_valid4, 1);
    check("w4_sum", s4, 4'h0);
    check("w4_co", co4, 1);
    out_ready4 = 1;
    @(posedge clk); #1;
    out_ready4 = 0;
    check("w4_in_ready", in_ready4, 1);

    // latency: out_valid rises exactly 4 edges after accept
    issue(16'h1234, 16'h4321, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check("latency", out_valid, (k == 4));
    end
    drain(0);

    issue(16'hFFFF, 16'h0001, 1'b0); drain(0);
    issue(16'hFFFF, 16'hFFFF, 1'b1); drain(0);

    // back-pressure in DONE with in_valid and a toggling
    issue(16'hA5A5, 16'h1234, 1'b1);
    for (int t = 0; t < 20 && !out_valid; t++) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 5; k++) begin
      in_valid = ~in_valid;
      a        = W'($urandom);
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      if (sb.size() > 0) begin
        check("bp_s_stable", s, sb[0].s);
        check("bp_co_stable", co, sb[0].co);
      end
    end
    in_valid  = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_valid", out_valid, 0);

    // reset while idx=2
    issue(16'h1234, 16'h1111, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_s", s, 0);
    check("midrst_co", co, 0);
    issue(16'h0001, 16'h0001, 1'b0); drain(0);

    // signed overflow corners
    issue(16'h7FFF, 16'h0001, 1'b0); drain(0);
    issue(16'h8000, 16'hFFFF, 1'b0); drain(0);
    issue(16'h7FFF, 16'h0000, 1'b1); drain(0);

    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      drain(1);
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
